// File: rtl/ahb_arbiter_if.sv
// Arbitration signal bundle for ahb_arbiter: requests, locks and shared transfer
// status come from the bus, grant and owner indication go back out.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [1:0]             HRESP;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [3:0]             HMASTER;
  logic                   HMASTLOCK;

  // Bus/master side: drives requests and transfer status, observes grant.
  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  // Arbiter side.
  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter with burst tracking and locked-transfer support.
// Macro AHB_ARB_ROUND_ROBIN_EN selects round-robin; default is fixed priority.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  ahb_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  logic [3:0]             beats_q, beats_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [3:0]             hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [IDX_W-1:0]       winner;
  logic                   lock_active;
  logic                   rearb;
  logic                   err_start;

  // Remaining beats of the fixed-length burst currently on the bus.
  always_comb begin
    beats_d   = beats_q;
    err_start = !bus.HREADY && (bus.HRESP != RESP_OKAY);
    if (err_start) begin
      beats_d = 4'd0;
    end else if (bus.HREADY && bus.HTRANS == TRANS_NONSEQ) begin
      case (bus.HBURST)
        3'b010, 3'b011: beats_d = 4'd3;
        3'b100, 3'b101: beats_d = 4'd7;
        3'b110, 3'b111: beats_d = 4'd15;
        default:        beats_d = 4'd0;
      endcase
    end else if (bus.HREADY && bus.HTRANS == TRANS_SEQ && beats_q != 4'd0) begin
      beats_d = beats_q - 4'd1;
    end
  end

  // last_grant_q always equals the index of the asserted HGRANT bit.
  assign lock_active = bus.HLOCK[last_grant_q];
  assign rearb       = bus.HREADY && !lock_active && (beats_d == 4'd0);

  always_comb begin
    winner = DEF_IDX;
    if (|bus.HBUSREQ) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
      // Walk offsets from farthest to nearest so the nearest requester after
      // last_grant wins; offset NUM_MASTERS is the owner itself.
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        if (bus.HBUSREQ[IDX_W'((int'(last_grant_q) + k) % NUM_MASTERS)]) begin
          winner = IDX_W'((int'(last_grant_q) + k) % NUM_MASTERS);
        end
      end
`else
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        if (bus.HBUSREQ[IDX_W'(k)]) begin
          winner = IDX_W'(k);
        end
      end
`endif
    end
  end

  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    if (rearb) begin
      grant_d      = NUM_MASTERS'(1) << winner;
      last_grant_d = winner;
    end
  end

  // Owner indication follows the grant one accepted transfer later.
  always_comb begin
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (bus.HREADY) begin
      hmaster_d   = 4'(last_grant_q);
      hmastlock_d = lock_active;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      beats_q      <= 4'd0;
      last_grant_q <= DEF_IDX;
      grant_q      <= DEF_GRANT;
      hmaster_q    <= 4'(DEFAULT_MASTER);
      hmastlock_q  <= 1'b0;
    end else begin
      beats_q      <= beats_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      hmaster_q    <= hmaster_d;
      hmastlock_q  <= hmastlock_d;
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios plus randomized
// traffic against a transfer-level reference model.
module tb_ahb_arbiter;
  localparam int N = 4;

  logic hclk;
  logic hresetn;
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int   m_beats;
  int   m_owner;
  int   m_hmaster;
  bit   m_hmastlock;

  ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
    .HCLK    (hclk),
    .HRESETn (hresetn),
    .bus     (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic int burst_len(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic int pick_winner();
    if (bus.HBUSREQ == '0) return 0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      if (bus.HBUSREQ[(m_owner + k) % N]) return (m_owner + k) % N;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (bus.HBUSREQ[k]) return k;
    end
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_beats = 0; m_owner = 0; m_hmaster = 0; m_hmastlock = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int nb;
    nb = m_beats;
    if (!bus.HREADY && bus.HRESP != 2'b00) nb = 0;
    else if (bus.HREADY && bus.HTRANS == 2'b10) nb = burst_len(bus.HBURST) - 1;
    else if (bus.HREADY && bus.HTRANS == 2'b11 && m_beats > 0) nb = m_beats - 1;
    if (bus.HREADY) begin
      m_hmaster   = m_owner;
      m_hmastlock = bus.HLOCK[m_owner];
    end
    if (bus.HREADY && !bus.HLOCK[m_owner] && nb == 0) m_owner = pick_winner();
    m_beats = nb;
  endtask

  task automatic tick();
    model_edge();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                       input logic [2:0] burst, input logic ready, input logic [1:0] resp);
    bus.HBUSREQ = req; bus.HLOCK = lock; bus.HTRANS = trans;
    bus.HBURST = burst; bus.HREADY = ready; bus.HRESP = resp;
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    drive(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    drive(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    @(posedge hclk);
    #1;
    total++; if (bus.HGRANT !== 4'b0001) begin bad++; $display("FAIL reset_grant: got %b want 0001", bus.HGRANT); end
    total++; if (bus.HMASTER !== 4'd0) begin bad++; $display("FAIL reset_hmaster: got %0d want 0", bus.HMASTER); end
    total++; if (bus.HMASTLOCK !== 1'b0) begin bad++; $display("FAIL reset_hmastlock: got %b want 0", bus.HMASTLOCK); end
    hresetn = 1'b1;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (bus.HGRANT !== 4'b0001) begin bad++; $display("FAIL idle_grant c%0d: got %b want 0001", c, bus.HGRANT); end
      total++; if (bus.HMASTER !== 4'd0) begin bad++; $display("FAIL idle_hmaster c%0d: got %0d want 0", c, bus.HMASTER); end
      total++; if (bus.HMASTLOCK !== 1'b0) begin bad++; $display("FAIL idle_hmastlock c%0d: got %b want 0", c, bus.HMASTLOCK); end
    end
    $display("test_reset complete");
  endtask

  task automatic test_midburst_reset();
    drive(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00); tick();
    drive(4'b0100, 4'b0000, 2'b10, 3'b111, 1'b1, 2'b00); tick();
    drive(4'b0100, 4'b0000, 2'b11, 3'b111, 1'b1, 2'b00); tick(); tick();
    total++; if (bus.HGRANT !== 4'b0100) begin bad++; $display("FAIL midrst_pre_grant: got %b want 0100", bus.HGRANT); end
    #3 hresetn = 1'b0;
    #1;
    total++; if (bus.HGRANT !== 4'b0001) begin bad++; $display("FAIL midrst_async_grant: got %b want 0001", bus.HGRANT); end
    total++; if (bus.HMASTER !== 4'd0) begin bad++; $display("FAIL midrst_async_hmaster: got %0d want 0", bus.HMASTER); end
    total++; if (bus.HMASTLOCK !== 1'b0) begin bad++; $display("FAIL midrst_async_hmastlock: got %b want 0", bus.HMASTLOCK); end
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    model_reset();
    // A stray SEQ must not resurrect the aborted burst: the arbiter re-arbitrates.
    drive(4'b0010, 4'b0000, 2'b11, 3'b111, 1'b1, 2'b00); tick();
    total++; if (bus.HGRANT !== 4'b0010) begin bad++; $display("FAIL midrst_cleared_grant: got %b want 0010", bus.HGRANT); end
    drive(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    $display("test_midburst_reset complete");
  endtask

  task automatic test_burst_handover();
    drive(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00); tick();
    total++; if (bus.HGRANT !== 4'b0100) begin bad++; $display("FAIL burst_grant_m2: got %b want 0100", bus.HGRANT); end
    drive(4'b0100, 4'b0000, 2'b10, 3'b011, 1'b1, 2'b00); tick();
    total++; if (bus.HGRANT !== 4'b0100) begin bad++; $display("FAIL burst_beat1_grant: got %b want 0100", bus.HGRANT); end
    total++; if (bus.HMASTER !== 4'd2) begin bad++; $display("FAIL burst_beat1_hmaster: got %0d want 2", bus.HMASTER); end
    drive(4'b0110, 4'b0000, 2'b11, 3'b011, 1'b1, 2'b00); tick();
    total++; if (bus.HGRANT !== 4'b0100) begin bad++; $display("FAIL burst_beat2_grant: got %b want 0100", bus.HGRANT); end
    tick();
    total++; if (bus.HGRANT !== 4'b0100) begin bad++; $display("FAIL burst_beat3_grant: got %b want 0100", bus.HGRANT); end
    tick();
    total++; if (bus.HGRANT !== 4'b0010) begin bad++; $display("FAIL burst_beat4_grant: got %b want 0010", bus.HGRANT); end
    total++; if (bus.HMASTER !== 4'd2) begin bad++; $display("FAIL burst_beat4_hmaster: got %0d want 2", bus.HMASTER); end
    drive(4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00); tick();
    total++; if (bus.HGRANT !== 4'b0010) begin bad++; $display("FAIL burst_after_grant: got %b want 0010", bus.HGRANT); end
    total++; if (bus.HMASTER !== 4'd1) begin bad++; $display("FAIL burst_after_hmaster: got %0d want 1", bus.HMASTER); end
    $display("test_burst_handover complete");
  endtask

  task automatic test_lock();
    drive(4'b1000, 4'b1000, 2'b00, 3'b000, 1'b1, 2'b00); tick();
    total++; if (bus.HGRANT !== 4'b1000) begin bad++; $display("FAIL lock_grant_m3: got %b want 1000", bus.HGRANT); end
    for (int t = 0; t < 3; t++) begin
      drive(4'b1001, 4'b1000, 2'b10, 3'b000, 1'b1, 2'b00); tick();
      total++; if (bus.HGRANT !== 4'b1000) begin bad++; $display("FAIL lock_t%0d_grant: got %b want 1000", t, bus.HGRANT); end
      total++; if (bus.HMASTER !== 4'd3) begin bad++; $display("FAIL lock_t%0d_hmaster: got %0d want 3", t, bus.HMASTER); end
      total++; if (bus.HMASTLOCK !== 1'b1) begin bad++; $display("FAIL lock_t%0d_hmastlock: got %b want 1", t, bus.HMASTLOCK); end
    end
    drive(4'b0001, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00); tick();
    total++; if (bus.HGRANT !== 4'b0001) begin bad++; $display("FAIL unlock_grant: got %b want 0001", bus.HGRANT); end
    total++; if (bus.HMASTLOCK !== 1'b0) begin bad++; $display("FAIL unlock_hmastlock: got %b want 0", bus.HMASTLOCK); end
    tick();
    total++; if (bus.HMASTER !== 4'd0) begin bad++; $display("FAIL unlock_hmaster: got %0d want 0", bus.HMASTER); end
    $display("test_lock complete");
  endtask

  task automatic test_error();
    drive(4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00); tick();
    drive(4'b0010, 4'b0000, 2'b10, 3'b101, 1'b1, 2'b00); tick();
    drive(4'b0010, 4'b0000, 2'b11, 3'b101, 1'b1, 2'b00); tick(); tick();
    total++; if (bus.HGRANT !== 4'b0010) begin bad++; $display("FAIL err_pre_grant: got %b want 0010", bus.HGRANT); end
    drive(4'b0110, 4'b0000, 2'b11, 3'b101, 1'b0, 2'b01); tick();
    total++; if (bus.HGRANT !== 4'b0010) begin bad++; $display("FAIL err_stall_grant: got %b want 0010", bus.HGRANT); end
    drive(4'b0100, 4'b0000, 2'b00, 3'b101, 1'b1, 2'b01); tick();
    total++; if (bus.HGRANT !== 4'b0100) begin bad++; $display("FAIL err_handover_grant: got %b want 0100", bus.HGRANT); end
    drive(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    $display("test_error complete");
  endtask

  task automatic test_stall();
    drive(4'b0100, 4'b0100, 2'b00, 3'b000, 1'b1, 2'b00); tick(); tick();
    total++; if (bus.HMASTLOCK !== 1'b1) begin bad++; $display("FAIL stall_pre_hmastlock: got %b want 1", bus.HMASTLOCK); end
    for (int c = 0; c < 5; c++) begin
      drive(4'($urandom), 4'($urandom), 2'($urandom), 3'($urandom), 1'b0, 2'b00); tick();
      total++; if (bus.HGRANT !== 4'b0100) begin bad++; $display("FAIL stall_c%0d_grant: got %b want 0100", c, bus.HGRANT); end
      total++; if (bus.HMASTER !== 4'd2) begin bad++; $display("FAIL stall_c%0d_hmaster: got %0d want 2", c, bus.HMASTER); end
      total++; if (bus.HMASTLOCK !== 1'b1) begin bad++; $display("FAIL stall_c%0d_hmastlock: got %b want 1", c, bus.HMASTLOCK); end
    end
    drive(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 2'b00);
    $display("test_stall complete");
  endtask

  task automatic test_policy();
    logic [3:0] want;
    int         idx;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, 2'b00); tick();
`ifdef AHB_ARB_ROUND_ROBIN_EN
      idx = (k + 1) % N;
`else
      idx = 0;
`endif
      want = 4'b0001 << idx;
      total++; if (bus.HGRANT !== want) begin bad++; $display("FAIL policy_k%0d_grant: got %b want %b", k, bus.HGRANT, want); end
    end
    $display("test_policy complete");
  endtask

  task automatic test_random();
    logic [3:0] want;
    logic       rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      drive(4'($urandom), (($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000),
            2'($urandom), 3'($urandom), rdy,
            (!rdy && $urandom_range(0, 3) == 0) ? 2'b01 : 2'b00);
      tick();
      want = 4'b0001 << m_owner;
      $display("rand c%0d req=%b rdy=%b grant=%b hmaster=%0d", c, bus.HBUSREQ, rdy, bus.HGRANT, bus.HMASTER);
      total++; if (bus.HGRANT !== want) begin bad++; $display("FAIL rand_c%0d_grant: got %b want %b", c, bus.HGRANT, want); end
      total++; if (bus.HMASTER !== 4'(m_hmaster)) begin bad++; $display("FAIL rand_c%0d_hmaster: got %0d want %0d", c, bus.HMASTER, m_hmaster); end
      total++; if (bus.HMASTLOCK !== m_hmastlock) begin bad++; $display("FAIL rand_c%0d_hmastlock: got %b want %b", c, bus.HMASTLOCK, m_hmastlock); end
    end
    $display("test_random complete");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_midburst_reset();
    test_burst_handover();
    test_lock();
    test_error();
    test_stall();
    test_policy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
